// File: rtl/prescaler_ctrl.sv
// Prescaler run controller: owns the divide down-counter and issues a one-cycle tick every (div+1) clocks.
// Latency: start in cycle 0 makes busy=1 from cycle 1 and the first tick lands in cycle div+1.
// Backpressure: cfg_ready drops while a mid-run config waits for a tick boundary, and returns the cycle after it applies.
module prescaler_ctrl #(
  parameter int COUNTER_WIDTH = 32,
  parameter int BURST_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [COUNTER_WIDTH-1:0] cfg_div,
  input  logic [BURST_WIDTH-1:0]   cfg_burst,
  input  logic                     start,
  input  logic                     stop,
  output logic                     tick,
  output logic                     busy,
  output logic                     done,
  output logic [BURST_WIDTH-1:0]   tick_cnt
);

  localparam logic [COUNTER_WIDTH-1:0] ONE_C = COUNTER_WIDTH'(1);
  localparam logic [BURST_WIDTH-1:0]   ONE_B = BURST_WIDTH'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state;
  logic [COUNTER_WIDTH-1:0] cnt;
  logic [COUNTER_WIDTH-1:0] div_sh;
  logic [COUNTER_WIDTH-1:0] pend_div;
  logic [BURST_WIDTH-1:0]   burst_sh;
  logic [BURST_WIDTH-1:0]   pend_burst;
  logic [BURST_WIDTH-1:0]   burst_act;
  logic                     pending;
  logic                     last;
  logic                     xfer;

  // Outputs are decodes of registered state only, so no input reaches them combinationally.
  assign busy      = (state == RUN);
  assign tick      = busy && (cnt == '0);
  assign last      = tick && (burst_act != '0) && ((tick_cnt + ONE_B) == burst_act);
  assign done      = last;
  assign cfg_ready = !busy || !pending;
  assign xfer      = cfg_valid && cfg_ready;

  // Run sequencing, counter, shadow/pending config bookkeeping and tick counting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      div_sh     <= '0;
      burst_sh   <= '0;
      pend_div   <= '0;
      pend_burst <= '0;
      pending    <= 1'b0;
      burst_act  <= '0;
      tick_cnt   <= '0;
    end else if (state == IDLE) begin
      if (xfer) begin
        div_sh   <= cfg_div;
        burst_sh <= cfg_burst;
      end
      // Stop outranks start; a config offered alongside start governs this run.
      if (start && !stop) begin
        state     <= RUN;
        cnt       <= xfer ? cfg_div : div_sh;
        burst_act <= xfer ? cfg_burst : burst_sh;
        tick_cnt  <= '0;
      end
    end else begin
      if (tick) begin
        tick_cnt <= tick_cnt + ONE_B;
      end
      if (stop || last) begin
        // Leaving RUN: fold any waiting or just-offered config into the shadows.
        state   <= IDLE;
        cnt     <= '0;
        pending <= 1'b0;
        if (xfer) begin
          div_sh   <= cfg_div;
          burst_sh <= cfg_burst;
        end else if (pending) begin
          div_sh   <= pend_div;
          burst_sh <= pend_burst;
        end
      end else begin
        if (tick) begin
          // Tick boundary: reload from the pending divide if present, so no period is cut short.
          cnt <= pending ? pend_div : div_sh;
          if (pending) begin
            div_sh   <= pend_div;
            burst_sh <= pend_burst;
            pending  <= 1'b0;
          end
        end else begin
          cnt <= cnt - ONE_C;
        end
        // A config accepted in a tick cycle (pending was clear) waits for the following tick.
        if (xfer) begin
          pend_div   <= cfg_div;
          pend_burst <= cfg_burst;
          pending    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prescaler_ctrl.sv
// Bench for prescaler_ctrl: directed scenarios plus a randomized run against a tick-time reference model.
// Inputs are driven 1ns after the rising edge; outputs are sampled before the next rising edge.
// The model tracks absolute tick times, shadow/pending config and tick counts rather than a down-counter.
module tb_prescaler_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_div;
  logic [15:0] cfg_burst;
  logic        start;
  logic        stop;
  logic        tick;
  logic        busy;
  logic        done;
  logic [15:0] tick_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state
  bit          m_run;
  bit          m_pend;
  logic [31:0] m_div_sh;
  logic [31:0] m_pend_div;
  logic [15:0] m_burst_sh;
  logic [15:0] m_pend_burst;
  logic [15:0] m_burst_act;
  logic [15:0] m_cnt;
  int          m_next_tick;
  bit          e_tick, e_done, e_busy, e_ready;

  prescaler_ctrl #(.COUNTER_WIDTH(32), .BURST_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_burst(cfg_burst), .start(start), .stop(stop),
    .tick(tick), .busy(busy), .done(done), .tick_cnt(tick_cnt)
  );

  always #5 clk = ~clk;

  task automatic clk_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    cfg_valid = 1'b0;
    cfg_div   = '0;
    cfg_burst = '0;
    start     = 1'b0;
    stop      = 1'b0;
  endtask

  task automatic model_reset();
    m_run = 0; m_pend = 0;
    m_div_sh = '0; m_pend_div = '0; m_burst_sh = '0; m_pend_burst = '0;
    m_burst_act = '0; m_cnt = '0; m_next_tick = 0;
  endtask

  task automatic model_predict();
    e_busy  = m_run;
    e_tick  = m_run && (cyc == m_next_tick);
    e_done  = e_tick && (m_burst_act != 16'd0) && ((m_cnt + 16'd1) == m_burst_act);
    e_ready = !m_run || !m_pend;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    bit x;
    x = cfg_valid && e_ready;
    if (!m_run) begin
      if (x) begin m_div_sh = cfg_div; m_burst_sh = cfg_burst; end
      if (start && !stop) begin
        m_run       = 1;
        m_next_tick = cyc + 1 + int'(m_div_sh);
        m_burst_act = m_burst_sh;
        m_cnt       = '0;
      end
    end else begin
      if (e_tick) m_cnt = m_cnt + 16'd1;
      if (stop || e_done) begin
        m_run = 0;
        if (x) begin m_div_sh = cfg_div; m_burst_sh = cfg_burst; end
        else if (m_pend) begin m_div_sh = m_pend_div; m_burst_sh = m_pend_burst; end
        m_pend = 0;
      end else begin
        if (e_tick) begin
          if (m_pend) begin m_div_sh = m_pend_div; m_burst_sh = m_pend_burst; m_pend = 0; end
          m_next_tick = cyc + 1 + int'(m_div_sh);
        end
        if (x) begin m_pend_div = cfg_div; m_pend_burst = cfg_burst; m_pend = 1; end
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    clk_step();
    clk_step();
    rst_n = 1'b1;
    checks++;
    if ({tick, busy, done, cfg_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_flags got tick/busy/done/ready=%b want 0001", {tick, busy, done, cfg_ready});
    end
    checks++;
    if (tick_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_tick_cnt got %0d want 0", tick_cnt);
    end
  endtask

  task automatic test_continuous();
    cfg_valid = 1; cfg_div = 3; cfg_burst = 0;
    clk_step();
    idle_inputs();
    start = 1;
    clk_step();
    start = 0;
    for (int k = 1; k <= 13; k++) begin
      checks++;
      if ({tick, busy, done} !== {(k % 4) == 0, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL cont_cycle%0d got tick/busy/done=%b want %b", k, {tick, busy, done}, {(k % 4) == 0, 1'b1, 1'b0});
      end
      if (k == 13) begin
        checks++;
        if (tick_cnt !== 16'd3) begin
          failures++;
          $display("FAIL cont_tick_cnt got %0d want 3", tick_cnt);
        end
      end
      clk_step();
    end
    stop = 1;
    clk_step();
    stop = 0;
    checks++;
    if ({tick, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL cont_stopped got tick/busy/done=%b want 000", {tick, busy, done});
    end
  endtask

  task automatic test_burst();
    logic [15:0] ec;
    for (int rep = 0; rep < 2; rep++) begin
      if (rep == 0) begin
        cfg_valid = 1; cfg_div = 1; cfg_burst = 4;
        clk_step();
        idle_inputs();
      end
      start = 1;
      clk_step();
      start = 0;
      for (int k = 1; k <= 9; k++) begin
        ec = 16'((k - 1) / 2);
        checks++;
        if ({tick, busy, done} !== {(k <= 8) && (k % 2 == 0), k <= 8, k == 8}) begin
          failures++;
          $display("FAIL burst_r%0d_c%0d got tick/busy/done=%b want %b", rep, k, {tick, busy, done},
                   {(k <= 8) && (k % 2 == 0), k <= 8, k == 8});
        end
        checks++;
        if (tick_cnt !== ec) begin
          failures++;
          $display("FAIL burst_cnt_r%0d_c%0d got %0d want %0d", rep, k, tick_cnt, ec);
        end
        clk_step();
      end
    end
  endtask

  task automatic test_midrun_cfg();
    bit et;
    cfg_valid = 1; cfg_div = 5; cfg_burst = 0;
    clk_step();
    idle_inputs();
    start = 1;
    clk_step();
    start = 0;
    for (int k = 1; k <= 16; k++) begin
      cfg_valid = (k >= 3 && k <= 6);
      cfg_div   = (k == 3) ? 32'd2 : 32'd7;
      et = (k == 6) || (k > 6 && ((k - 6) % 3) == 0);
      checks++;
      if ({tick, cfg_ready} !== {et, !(k >= 4 && k <= 6)}) begin
        failures++;
        $display("FAIL midcfg_c%0d got tick/ready=%b want %b", k, {tick, cfg_ready}, {et, !(k >= 4 && k <= 6)});
      end
      clk_step();
    end
    idle_inputs();
    stop = 1;
    clk_step();
    stop = 0;
  endtask

  task automatic test_stop();
    cfg_valid = 1; cfg_div = 2; cfg_burst = 10;
    clk_step();
    idle_inputs();
    start = 1;
    clk_step();
    start = 0;
    for (int k = 1; k <= 7; k++) begin
      stop = (k == 6);
      checks++;
      if ({tick, busy, done} !== {(k % 3) == 0 && k <= 6, k <= 6, 1'b0}) begin
        failures++;
        $display("FAIL stop_tick_c%0d got tick/busy/done=%b want %b", k, {tick, busy, done},
                 {(k % 3) == 0 && k <= 6, k <= 6, 1'b0});
      end
      if (k == 7) begin
        checks++;
        if (tick_cnt !== 16'd2) begin
          failures++;
          $display("FAIL stop_tick_cnt got %0d want 2", tick_cnt);
        end
      end
      clk_step();
    end
    stop = 0;
    start = 1;
    clk_step();
    start = 0;
    stop = 1;
    clk_step();
    stop = 0;
    for (int k = 2; k <= 8; k++) begin
      checks++;
      if ({tick, busy, done, tick_cnt} !== {3'b000, 16'd0}) begin
        failures++;
        $display("FAIL stop_notick_c%0d got tick/busy/done=%b cnt=%0d want 000 cnt=0", k, {tick, busy, done}, tick_cnt);
      end
      clk_step();
    end
  endtask

  task automatic test_bypass();
    cfg_valid = 1; cfg_div = 0; cfg_burst = 2; start = 1;
    clk_step();
    idle_inputs();
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if ({tick, busy, done} !== {k <= 2, k <= 2, k == 2}) begin
        failures++;
        $display("FAIL bypass_c%0d got tick/busy/done=%b want %b", k, {tick, busy, done}, {k <= 2, k <= 2, k == 2});
      end
      clk_step();
    end
    start = 1; stop = 1;
    clk_step();
    idle_inputs();
    for (int k = 1; k <= 2; k++) begin
      checks++;
      if ({tick, busy, done, tick_cnt} !== {3'b000, 16'd2}) begin
        failures++;
        $display("FAIL startstop_c%0d got tick/busy/done=%b cnt=%0d want 000 cnt=2", k, {tick, busy, done}, tick_cnt);
      end
      clk_step();
    end
  endtask

  task automatic test_reset_midrun();
    cfg_valid = 1; cfg_div = 4; cfg_burst = 0;
    clk_step();
    idle_inputs();
    start = 1;
    clk_step();
    start = 0;
    clk_step();
    cfg_valid = 1; cfg_div = 6;
    clk_step();
    idle_inputs();
    checks++;
    if (cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_pending_ready got %b want 0", cfg_ready);
    end
    rst_n = 0;
    clk_step();
    rst_n = 1;
    checks++;
    if ({tick, busy, done, cfg_ready, tick_cnt} !== {4'b0001, 16'd0}) begin
      failures++;
      $display("FAIL rstmid_outputs got tick/busy/done/ready=%b cnt=%0d want 0001 cnt=0", {tick, busy, done, cfg_ready}, tick_cnt);
    end
    start = 1;
    clk_step();
    start = 0;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if ({tick, busy, done, tick_cnt} !== {3'b110, 16'(k - 1)}) begin
        failures++;
        $display("FAIL rstmid_div0_c%0d got tick/busy/done=%b cnt=%0d want 110 cnt=%0d", k, {tick, busy, done}, tick_cnt, k - 1);
      end
      clk_step();
    end
    stop = 1;
    clk_step();
    stop = 0;
  endtask

  task automatic test_random();
    idle_inputs();
    rst_n = 0;
    clk_step();
    rst_n = 1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      cfg_valid = ($urandom_range(3) == 0);
      cfg_div   = 32'($urandom_range(5));
      cfg_burst = 16'($urandom_range(4));
      start     = ($urandom_range(7) == 0);
      stop      = ($urandom_range(24) == 0);
      model_predict();
      checks++;
      if ({tick, busy, done, cfg_ready} !== {e_tick, e_busy, e_done, e_ready}) begin
        failures++;
        $display("FAIL rand_flags_n%0d got tick/busy/done/ready=%b want %b", n, {tick, busy, done, cfg_ready},
                 {e_tick, e_busy, e_done, e_ready});
      end
      checks++;
      if (tick_cnt !== m_cnt) begin
        failures++;
        $display("FAIL rand_tick_cnt_n%0d got %0d want %0d", n, tick_cnt, m_cnt);
      end
      model_step();
      clk_step();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_burst();
    test_midrun_cfg();
    test_stop();
    test_bypass();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
